// File: rtl/pixel_stream_reader.sv
// ============================================================================
// pixel_stream_reader: fetches packed pixel words from result memory and
// streams them one pixel per cycle to the GPIO output stage.  Rev 1.0
// ============================================================================
`default_nettype none

module pixel_stream_reader #(
  parameter int IMG_PIXELS  = 160000,
  parameter int LANES       = 4,
  parameter int ADDR_W      = 16,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [8*LANES-1:0]   mem_rdata,
  output logic [7:0]           pixel_out,
  output logic                 pixel_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int NWORDS = IMG_PIXELS / LANES;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W  = $clog2(FIFO_DEPTH + MEM_LATENCY + 2);
  localparam int PIX_W  = $clog2(IMG_PIXELS + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);
  localparam logic [PIX_W-1:0]  PIX_TOTAL = PIX_W'(IMG_PIXELS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state, state_next;
  logic [ADDR_W-1:0]    word_cnt;
  logic [MEM_LATENCY-1:0] track;
  logic [8*LANES-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]     fifo_cnt;
  logic [LANE_W-1:0]    lane;
  logic [PIX_W-1:0]     pix_cnt;

  logic                 issue, push, pop, emit, credit_ok;
  logic [ADDR_W-1:0]    issue_addr;
  logic [OUT_W-1:0]     outstanding;
  logic [7:0]           head_lanes [LANES];

  // Credits cover buffered words, words in the memory pipe, and the request
  // currently on the bus, so the FIFO can never be overrun.
  always_comb begin
    outstanding = OUT_W'(fifo_cnt) + OUT_W'(mem_rd_en);
    for (int i = 0; i < MEM_LATENCY; i++) begin
      outstanding = outstanding + OUT_W'(track[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      head_lanes[i] = fifo_mem[rd_ptr][8*i +: 8];
    end
  end

  assign credit_ok = (outstanding < OUT_W'(FIFO_DEPTH));
  assign push      = track[MEM_LATENCY-1];
  assign emit      = !hold && (fifo_cnt != '0);
  assign pop       = emit && (lane == LAST_LANE);

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    issue_addr = (state == S_IDLE) ? '0 : word_cnt;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          issue      = 1'b1;
          state_next = (LAST_ADDR == '0) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (word_cnt == LAST_ADDR) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pix_cnt == PIX_TOTAL) state_next = S_DONE;
      end
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      track       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      lane        <= '0;
      pix_cnt     <= '0;
      mem_rd_en   <= 1'b0;
      mem_addr    <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_next;
      busy      <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done      <= (state_next == S_DONE);
      mem_rd_en <= issue;
      if (issue) begin
        mem_addr <= issue_addr;
        word_cnt <= issue_addr + ADDR_W'(1);
      end

      track[0] <= mem_rd_en;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        track[i] <= track[i-1];
      end

      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);

      pixel_valid <= emit;
      if (emit) begin
        pixel_out <= head_lanes[lane];
        lane      <= pop ? '0 : lane + LANE_W'(1);
      end

      if ((state == S_IDLE) && start) pix_cnt <= '0;
      else if (emit)                  pix_cnt <= pix_cnt + PIX_W'(1);
    end
  end

endmodule

`default_nettype wire
